fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of the async FIFO (beh_fifo) among NREQ requesters.

---
 rtl/fifo_wr_arbiter_if.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the round-robin arbiter and the FIFO write port.
// The slave modport is the arbiter's view; master is the requester/FIFO environment.
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;

  modport master (
    output req_valid,
    output req_data,
    output wfull,
    input  req_ready,
    input  winc,
    input  wdata
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  wfull,
    output req_ready,
    output winc,
    output wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Each grant lasts up to BURST_LEN words or until the owner drops valid.
module fifo_wr_arbiter #(
  parameter  int DSIZE     = 8,
  parameter  int NREQ      = 4,
  parameter  int BURST_LEN = 4,
  parameter  int CNT_W     = 16,
  localparam int GW        = $clog2(NREQ)
) (
  input  logic                 wclk,
  input  logic                 wrst,
  fifo_wr_arbiter_if.slave     bus,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_count
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;

  logic [GW:0]        cand;
  logic [GW:0]        ptr_w;
  logic [GW-1:0]      pick_idx;
  logic               pick_found;
  logic [GW-1:0]      next_ptr;
  logic               gnt_valid;
  logic [DSIZE-1:0]   gnt_data;
  logic               xfer;
  logic [BW-1:0]      beat_inc;

  // Search starts at rr_ptr and wraps; the first valid requester in that order wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end
      if (!pick_found && bus.req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    ptr_w = {1'b0, grant_id_q} + (GW+1)'(1);
    if (ptr_w >= (GW+1)'(NREQ)) begin
      ptr_w = '0;
    end
    next_ptr = ptr_w[GW-1:0];
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        gnt_valid = bus.req_valid[i];
        gnt_data  = bus.req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  // The write strobe is purely combinational so a word moves in the same cycle it is offered.
  always_comb begin
    busy          = (state_q == GRANT);
    xfer          = busy & gnt_valid & ~bus.wfull;
    bus.winc      = xfer;
    bus.wdata     = xfer ? gnt_data : '0;
    bus.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = busy & ~bus.wfull & (grant_id_q == GW'(i));
    end
  end

  assign beat_inc = beat_cnt_q + BW'(1);

  // A last beat coinciding with a valid drop still yields exactly one exit and one pointer step.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    word_count_d = word_count_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_d   = beat_inc;
          word_count_d = word_count_q + CNT_W'(1);
        end
        if ((xfer && (beat_inc == BW'(BURST_LEN))) || !gnt_valid) begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  assign grant_id   = grant_id_q;
  assign word_count = word_count_q;

`ifndef SYNTHESIS
  a_no_write_when_full: assert property (@(posedge wclk) disable iff (wrst)
    bus.wfull |-> !bus.winc);
  a_ready_onehot0: assert property (@(posedge wclk) disable iff (wrst)
    $onehot0(bus.req_ready));
  a_winc_is_handshake: assert property (@(posedge wclk) disable iff (wrst)
    bus.winc == |(bus.req_valid & bus.req_ready));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based requesters, a per-cycle reference model of the
// round-robin rules, and literal checks on grant order, burst sizes and FIFO contents.
module tb_fifo_wr_arbiter;
  localparam int DSIZE     = 8;
  localparam int NREQ      = 4;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 16;
  localparam int GW        = 2;

  logic              wclk = 1'b0;
  logic              wrst;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic [CNT_W-1:0]  word_count;

  fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(
    .DSIZE(DSIZE), .NREQ(NREQ), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .bus(bus.slave),
    .grant_id(grant_id),
    .busy(busy),
    .word_count(word_count)
  );

  always #5 wclk = ~wclk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]      src[NREQ][$];
  bit              en[NREQ];
  int              pops[NREQ];
  logic [NREQ-1:0] acc_s = '0;
  int              stall_req  = -1;
  int              stall_after = 0;
  int              stall_left = 0;

  int         glog[$];
  int         blog[$];
  int         gaplog[$];
  logic [7:0] fifo_q[$];
  int         gap = 0;
  int         bw = 0;
  int         stall_busy = 0;
  logic       prev_busy = 1'b0;

  int              own_m = -1;
  int              taken_m = 0;
  int              rr_m = 0;
  int              gid_m = 0;
  int              wc_m = 0;
  int              idx;
  logic [NREQ-1:0] mv;
  logic            mf;
  logic            exp_busy, exp_winc;
  logic [NREQ-1:0] exp_ready;
  logic [7:0]      exp_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = en[i] && (src[i].size() > 0);
      bus.req_data[i*DSIZE +: DSIZE] = bus.req_valid[i] ? src[i][0] : 8'h00;
    end
    bus.wfull = (stall_left > 0);
  endtask

  // One clock: retire words accepted at this edge, then present the next inputs.
  task automatic applyStimulus();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_s[i]) begin
        void'(src[i].pop_front());
        pops[i]++;
      end
    end
    if (stall_req >= 0 && pops[stall_req] == stall_after) begin
      stall_left = 5;
      stall_req  = -1;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    driveInputs();
  endtask

  task automatic clearLogs();
    glog.delete();
    blog.delete();
    gaplog.delete();
    fifo_q.delete();
    stall_busy = 0;
    for (int i = 0; i < NREQ; i++) pops[i] = 0;
  endtask

  task automatic clearAll();
    for (int i = 0; i < NREQ; i++) begin
      src[i].delete();
      en[i] = 1'b0;
    end
    stall_req  = -1;
    stall_left = 0;
    clearLogs();
  endtask

  // Called right after applyStimulus so reset lands between edges.
  task automatic resetDut();
    #1;
    wrst = 1'b1;
    #1;
    checkOutput("rst_async_winc", bus.winc, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_word_count", word_count, 0);
    applyStimulus();
    applyStimulus();
    #1;
    wrst = 1'b0;
    clearLogs();
  endtask

  task automatic runUntilIdle(input int maxc);
    bit done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      applyStimulus();
      done = !busy;
      for (int i = 0; i < NREQ; i++) begin
        if (en[i] && src[i].size() > 0) done = 1'b0;
      end
    end
    checkOutput("drain_done", done, 1);
    applyStimulus();
    applyStimulus();
  endtask

  always @(negedge wclk) begin
    mv = bus.req_valid;
    mf = bus.wfull;
    if (wrst) begin
      own_m = -1; taken_m = 0; rr_m = 0; gid_m = 0; wc_m = 0;
    end
    exp_busy  = (own_m >= 0);
    exp_ready = '0;
    exp_winc  = 1'b0;
    exp_wdata = 8'h00;
    if (exp_busy) begin
      if (!mf) exp_ready[own_m] = 1'b1;
      exp_winc = mv[own_m] && !mf;
      if (exp_winc) exp_wdata = bus.req_data[own_m*DSIZE +: DSIZE];
    end
    checkOutput("busy", busy, exp_busy);
    checkOutput("req_ready", bus.req_ready, exp_ready);
    checkOutput("winc", bus.winc, exp_winc);
    checkOutput("wdata", bus.wdata, exp_wdata);
    checkOutput("grant_id", grant_id, gid_m);
    checkOutput("word_count", word_count, wc_m);

    acc_s = wrst ? '0 : (bus.req_valid & bus.req_ready);
    if (busy && !prev_busy) begin
      glog.push_back(int'(grant_id));
      gaplog.push_back(gap);
      gap = 0;
      bw  = 0;
    end
    if (!busy && prev_busy) blog.push_back(bw);
    if (!busy) gap++;
    if (bus.winc) bw++;
    if (busy && bus.wfull) stall_busy++;
    if (bus.winc && fifo_q.size() < 64) fifo_q.push_back(bus.wdata);
    prev_busy = busy;

    if (!wrst) begin
      if (own_m < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (rr_m + k) % NREQ;
          if (own_m < 0 && mv[idx]) begin
            own_m = idx; gid_m = idx; taken_m = 0;
          end
        end
      end else if (mv[own_m] && !mf) begin
        taken_m++;
        wc_m = (wc_m + 1) % 65536;
        if (taken_m == BURST_LEN) begin
          rr_m = (own_m + 1) % NREQ; own_m = -1;
        end
      end else if (!mv[own_m]) begin
        rr_m = (own_m + 1) % NREQ; own_m = -1;
      end
    end
  end

  initial begin
    wrst          = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
    clearAll();
    #2;
    checkOutput("reset_winc", bus.winc, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_grant_id", grant_id, 0);
    checkOutput("reset_word_count", word_count, 0);
    checkOutput("reset_req_ready", bus.req_ready, 0);
    checkOutput("reset_wdata", bus.wdata, 0);
    applyStimulus();
    applyStimulus();
    #1;
    wrst = 1'b0;

    // T1: reset in the middle of req3's burst, while the pointer sits at 2.
    for (int k = 0; k < 8; k++) src[1].push_back(8'h20 + 8'(k));
    for (int k = 0; k < 4; k++) src[3].push_back(8'h30 + 8'(k));
    for (int i = 0; i < NREQ; i++) en[i] = 1'b1;
    for (int c = 0; c < 100 && pops[3] < 2; c++) applyStimulus();
    checkOutput("t1_mid_burst_reached", pops[3], 2);
    resetDut();
    runUntilIdle(200);
    checkOutput("t1_glog_nonempty", glog.size() > 0, 1);
    if (glog.size() > 0) checkOutput("t1_first_grant", glog[0], 1);

    // T2: single requester streaming eight words.
    clearAll();
    resetDut();
    for (int k = 0; k < 8; k++) src[1].push_back(8'h10 + 8'(k));
    en[1] = 1'b1;
    runUntilIdle(100);
    checkOutput("t2_fifo_size", fifo_q.size(), 8);
    for (int k = 0; k < 8 && k < fifo_q.size(); k++)
      checkOutput($sformatf("t2_fifo_%0d", k), fifo_q[k], 32'h10 + k);
    checkOutput("t2_word_count", word_count, 8);
    checkOutput("t2_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      checkOutput("t2_grant0", glog[0], 1);
      checkOutput("t2_grant1", glog[1], 1);
      checkOutput("t2_gap", gaplog[1], 1);
    end
    if (blog.size() >= 2) begin
      checkOutput("t2_burst0", blog[0], 4);
      checkOutput("t2_burst1", blog[1], 4);
    end

    // T3: all four requesters continuously valid.
    clearAll();
    resetDut();
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 8; k++) src[i].push_back(8'(i * 16 + k));
      en[i] = 1'b1;
    end
    runUntilIdle(200);
    checkOutput("t3_grants", glog.size(), 8);
    if (glog.size() >= 5) begin
      checkOutput("t3_order0", glog[0], 0);
      checkOutput("t3_order1", glog[1], 1);
      checkOutput("t3_order2", glog[2], 2);
      checkOutput("t3_order3", glog[3], 3);
      checkOutput("t3_order4", glog[4], 0);
    end
    for (int b = 0; b < 4 && b < blog.size(); b++)
      checkOutput($sformatf("t3_burst%0d", b), blog[b], 4);
    for (int j = 0; j < fifo_q.size() && (j / 4) < glog.size(); j++)
      checkOutput($sformatf("t3_owner_w%0d", j), fifo_q[j][7:4], glog[j / 4]);
    checkOutput("t3_word_count", word_count, 32);

    // T4: five full cycles after the second beat of req2.
    clearAll();
    resetDut();
    for (int k = 0; k < 8; k++) src[2].push_back(8'h40 + 8'(k));
    en[2]       = 1'b1;
    stall_req   = 2;
    stall_after = 2;
    runUntilIdle(100);
    checkOutput("t4_fifo_size", fifo_q.size(), 8);
    for (int k = 0; k < 8 && k < fifo_q.size(); k++)
      checkOutput($sformatf("t4_fifo_%0d", k), fifo_q[k], 32'h40 + k);
    checkOutput("t4_stall_cycles", stall_busy, 5);
    if (blog.size() > 0) checkOutput("t4_burst0", blog[0], 4);
    checkOutput("t4_word_count", word_count, 8);

    // T5: req3 releases after two words; req0 and req1 arrive during its grant.
    clearAll();
    resetDut();
    src[3].push_back(8'h50);
    src[3].push_back(8'h51);
    en[3] = 1'b1; en[0] = 1'b1; en[1] = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    for (int k = 0; k < 3; k++) src[0].push_back(8'h60 + 8'(k));
    src[1].push_back(8'h70);
    runUntilIdle(100);
    checkOutput("t5_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      checkOutput("t5_grant0", glog[0], 3);
      checkOutput("t5_grant1", glog[1], 0);
      checkOutput("t5_grant2", glog[2], 1);
    end
    if (blog.size() >= 2) begin
      checkOutput("t5_burst0", blog[0], 2);
      checkOutput("t5_burst1", blog[1], 3);
    end
    checkOutput("t5_word_count", word_count, 6);

    // T6: 65537 words wrap the 16-bit counter to 1.
    clearAll();
    resetDut();
    for (int k = 0; k < 65537; k++) src[0].push_back(8'(k));
    en[0] = 1'b1;
    runUntilIdle(90000);
    checkOutput("t6_word_count", word_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
